// File: rtl/sfx_note_sequencer_pkg.sv
// Shared types for the sound-effect sequencer: FSM states, effect ids and ROM entry layout.
package sfx_note_sequencer_pkg;

  localparam int unsigned HpW  = 19;
  localparam int unsigned DurW = 10;

  localparam logic [1:0] SFX_REVEAL = 2'd0;
  localparam logic [1:0] SFX_FLAG   = 2'd1;
  localparam logic [1:0] SFX_MINE   = 2'd2;
  localparam logic [1:0] SFX_WIN    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap
  } state_e;

  typedef struct packed {
    logic [HpW-1:0]  hp;
    logic [DurW-1:0] dur;
    logic            last;
  } rom_entry_t;

  function automatic rom_entry_t mk_entry(int unsigned hp, int unsigned dur, logic last);
    rom_entry_t e;
    e.hp   = HpW'(hp);
    e.dur  = DurW'(dur);
    e.last = last;
    return e;
  endfunction

endpackage

// File: rtl/sfx_note_sequencer_if.sv
// Game-side request/status and DAC write-port signals of the sound-effect sequencer.
interface sfx_note_sequencer_if #(
  parameter int unsigned HP_W = 19
);
  logic            sfx_req;
  logic [1:0]      sfx_id;
  logic            mute;
  logic            audio_out_allowed;
  logic            write_audio_out;
  logic [31:0]     left_channel_audio_out;
  logic [31:0]     right_channel_audio_out;
  logic            busy;
  logic            sfx_done;
  logic [HP_W-1:0] cur_half_period;

  modport master (
    output sfx_req, sfx_id, mute, audio_out_allowed,
    input  write_audio_out, left_channel_audio_out, right_channel_audio_out,
    input  busy, sfx_done, cur_half_period
  );

  modport slave (
    input  sfx_req, sfx_id, mute, audio_out_allowed,
    output write_audio_out, left_channel_audio_out, right_channel_audio_out,
    output busy, sfx_done, cur_half_period
  );
endinterface

// File: rtl/sfx_note_sequencer_rom.sv
// Combinational note table: (effect id, note index) -> {half period, duration, last flag}.
module sfx_note_rom
  import sfx_note_sequencer_pkg::*;
(
  input  logic [1:0] sfx_id,
  input  logic [1:0] note_idx,
  output rom_entry_t entry
);

  always_comb begin
    entry = mk_entry(0, 1, 1'b1);
    unique case ({sfx_id, note_idx})
      {SFX_REVEAL, 2'd0}: entry = mk_entry(95555,  60, 1'b1);
      {SFX_FLAG,   2'd0}: entry = mk_entry(85132,  80, 1'b0);
      {SFX_FLAG,   2'd1}: entry = mk_entry(50620,  80, 1'b1);
      {SFX_MINE,   2'd0}: entry = mk_entry(50620, 100, 1'b0);
      {SFX_MINE,   2'd1}: entry = mk_entry(0,      50, 1'b0);
      {SFX_MINE,   2'd2}: entry = mk_entry(85132, 100, 1'b0);
      {SFX_MINE,   2'd3}: entry = mk_entry(95555, 300, 1'b1);
      {SFX_WIN,    2'd0}: entry = mk_entry(95555, 100, 1'b0);
      {SFX_WIN,    2'd1}: entry = mk_entry(85132, 100, 1'b0);
      {SFX_WIN,    2'd2}: entry = mk_entry(50620, 100, 1'b0);
      {SFX_WIN,    2'd3}: entry = mk_entry(47778, 200, 1'b1);
      default: ;
    endcase
  end

endmodule

// File: rtl/sfx_note_sequencer.sv
// Sound-effect sequencer: plays a ROM note list as a +/-AMPL square wave into the DAC write port.
module sfx_note_sequencer
  import sfx_note_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 10,
  parameter logic [31:0] AMPL      = 32'd10000000,
  parameter int unsigned HP_W      = HpW,
  parameter int unsigned DUR_W     = DurW
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  sfx_note_sequencer_if.slave bus
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW  = DUR_W + 1;

  state_e            state_q, state_d;
  logic [1:0]        id_q, id_d;
  logic [1:0]        note_idx_q, note_idx_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              last_q, last_d;
  logic              sq_q, sq_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [31:0]       sample_q, sample_d;

  rom_entry_t        rom_entry;
  logic              timed;
  logic              tick;
  logic [CntW-1:0]   dur_cnt_inc;
  logic              play_end;
  logic              gap_end;
  logic              done_fire;
  logic              preempt;

  sfx_note_rom u_rom (
    .sfx_id  (id_q),
    .note_idx(note_idx_q),
    .entry   (rom_entry)
  );

  assign timed       = (state_q == StPlay) || (state_q == StGap);
  assign tick        = timed && (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign dur_cnt_inc = {1'b0, dur_cnt_q} + CntW'(1);
  assign play_end    = (state_q == StPlay) && tick && (dur_cnt_inc >= {1'b0, dur_q});
  // dur_cnt doubles as the gap tick counter once the note has ended
  assign gap_end     = (state_q == StGap) && tick && (dur_cnt_inc >= CntW'(GAP_TICKS));
  assign done_fire   = gap_end && last_q;
  assign preempt     = bus.sfx_req && (state_q != StIdle) && (bus.sfx_id > id_q);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    note_idx_d = note_idx_q;
    hp_d       = hp_q;
    hp_cnt_d   = hp_cnt_q;
    dur_d      = dur_q;
    dur_cnt_d  = dur_cnt_q;
    last_d     = last_q;
    sq_d       = sq_q;
    tick_cnt_d = '0;
    if (timed) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.sfx_req) begin
          state_d    = StLoad;
          id_d       = bus.sfx_id;
          note_idx_d = 2'd0;
        end
      end
      StLoad: begin
        state_d   = StPlay;
        hp_d      = HP_W'(rom_entry.hp);
        dur_d     = DUR_W'(rom_entry.dur);
        last_d    = rom_entry.last;
        hp_cnt_d  = '0;
        dur_cnt_d = '0;
        sq_d      = 1'b0;
      end
      StPlay: begin
        if (hp_q == '0) begin
          hp_cnt_d = '0;
        end else if (hp_cnt_q == hp_q - HP_W'(1)) begin
          hp_cnt_d = '0;
          sq_d     = ~sq_q;
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
        if (tick) begin
          dur_cnt_d = play_end ? '0 : dur_cnt_inc[DUR_W-1:0];
        end
        if (play_end) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          dur_cnt_d = dur_cnt_inc[DUR_W-1:0];
        end
        if (gap_end) begin
          if (last_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StLoad;
            note_idx_d = note_idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion accepts any request; otherwise only a higher id may take over.
    if ((done_fire && bus.sfx_req) || (!done_fire && preempt)) begin
      state_d    = StLoad;
      id_d       = bus.sfx_id;
      note_idx_d = 2'd0;
    end
  end

  always_comb begin
    sample_d = 32'd0;
    if ((state_q == StPlay) && (hp_q != '0) && !bus.mute) begin
      sample_d = sq_q ? AMPL : (~AMPL + 32'd1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StIdle;
      id_q       <= 2'd0;
      note_idx_q <= 2'd0;
      hp_q       <= '0;
      hp_cnt_q   <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      last_q     <= 1'b0;
      sq_q       <= 1'b0;
      tick_cnt_q <= '0;
      sample_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      note_idx_q <= note_idx_d;
      hp_q       <= hp_d;
      hp_cnt_q   <= hp_cnt_d;
      dur_q      <= dur_d;
      dur_cnt_q  <= dur_cnt_d;
      last_q     <= last_d;
      sq_q       <= sq_d;
      tick_cnt_q <= tick_cnt_d;
      sample_q   <= sample_d;
    end
  end

  assign bus.write_audio_out         = bus.audio_out_allowed & ~reset;
  assign bus.left_channel_audio_out  = sample_q;
  assign bus.right_channel_audio_out = sample_q;
  assign bus.busy                    = (state_q != StIdle);
  assign bus.sfx_done                = done_fire & ~reset;
  assign bus.cur_half_period         = (state_q == StPlay) ? hp_q : '0;

endmodule

// File: tb/tb_sfx_note_sequencer.sv
// Bench for sfx_note_sequencer: vector table, corner sequences, random run against a schedule model.
module tb_sfx_note_sequencer;

  localparam int TD     = 4;
  localparam int GT     = 10;
  localparam int AUX_TD = 520;
  localparam logic [31:0] AMPL  = 32'd10000000;
  localparam logic [31:0] NAMPL = 32'hFF676980;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  sfx_note_sequencer_if bus ();
  sfx_note_sequencer_if bus2 ();

  sfx_note_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  sfx_note_sequencer #(.TICK_DIV(AUX_TD), .GAP_TICKS(GT)) dut_aux (
    .CLOCK_50(clk),
    .reset   (rst2),
    .bus     (bus2)
  );

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int aux_done_pulses = 0;
  bit aux_done = 0;

  int rom_hp  [4][4] = '{'{95555, 0, 0, 0}, '{85132, 50620, 0, 0},
                         '{50620, 0, 85132, 95555}, '{95555, 85132, 50620, 47778}};
  int rom_dur [4][4] = '{'{60, 0, 0, 0}, '{80, 80, 0, 0},
                         '{100, 50, 100, 300}, '{100, 100, 100, 200}};
  int n_notes [4]    = '{1, 2, 4, 4};

  typedef struct {
    int id;
    bit mute;
    int exp_cycles;
    int exp_hp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_and_load(input int id);
    bus.sfx_req = 1'b1;
    bus.sfx_id  = 2'(id);
    step();
    bus.sfx_req = 1'b0;
  endtask

  // Where an effect is, e cycles after it entered LOAD: ph 0=load 1=play 2=gap 3=past end.
  function automatic void locate(input int id, input int e, output int ph, output int hp,
                                 output int k, output bit fin);
    int rem;
    int pl;
    int gp;
    rem = e; ph = 3; hp = 0; k = 0; fin = 1'b0;
    gp  = GT * TD;
    for (int n = 0; n < n_notes[id]; n++) begin
      pl = rom_dur[id][n] * TD;
      hp = rom_hp[id][n];
      if (rem == 0) begin ph = 0; return; end
      rem -= 1;
      if (rem < pl) begin ph = 1; k = rem; return; end
      rem -= pl;
      if (rem < gp) begin
        ph = 2;
        fin = (n == n_notes[id] - 1) && (rem == gp - 1);
        return;
      end
      rem -= gp;
    end
    hp = 0;
  endfunction

  always @(negedge clk) begin
    if (bus.sfx_done) done_pulses++;
    if (bus2.sfx_done) aux_done_pulses++;
    if (bus.write_audio_out) check("lr_equal", bus.right_channel_audio_out,
                                   bus.left_channel_audio_out);
  end

  // Long-tick instance: square-wave toggle, mid-PLAY reset, replay after reset.
  initial begin
    rst2 = 1'b1;
    bus2.sfx_req = 1'b0; bus2.sfx_id = 2'd0; bus2.mute = 1'b0; bus2.audio_out_allowed = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.sfx_req = 1'b1; bus2.sfx_id = 2'd2;
    @(posedge clk); #1;
    bus2.sfx_req = 1'b0;
    @(posedge clk); #1;
    check("aux_play_hp", bus2.cur_half_period, 50620);
    @(posedge clk); #1;
    check("aux_first_low", bus2.left_channel_audio_out, NAMPL);
    repeat (50619) @(posedge clk);
    #1;
    check("aux_pre_toggle", bus2.left_channel_audio_out, NAMPL);
    @(posedge clk); #1;
    check("aux_post_toggle", bus2.left_channel_audio_out, AMPL);
    repeat (10) @(posedge clk);
    #1;
    check("aux_high_hold", bus2.right_channel_audio_out, AMPL);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    check("aux_rst_busy", bus2.busy, 0);
    check("aux_rst_sample", bus2.left_channel_audio_out, 0);
    check("aux_rst_hp", bus2.cur_half_period, 0);
    repeat (20) @(posedge clk);
    #1;
    check("aux_rst_no_done", aux_done_pulses, 0);
    bus2.sfx_req = 1'b1; bus2.sfx_id = 2'd0;
    @(posedge clk); #1;
    bus2.sfx_req = 1'b0;
    check("aux_replay_busy", bus2.busy, 1);
    @(posedge clk); #1;
    check("aux_replay_hp", bus2.cur_half_period, 95555);
    @(posedge clk); #1;
    check("aux_replay_sample", bus2.left_channel_audio_out, NAMPL);
    aux_done = 1'b1;
  end

  initial begin
    vec_t vecs[4];
    int   n, d0, e;
    bit   nz, bad, rest_nz;
    int   starts[4];
    int   mine_hp[4];
    bit   m_active;
    int   m_id, m_start, t, ph, hp, k;
    bit   fin;
    logic [31:0] m_sample;

    vecs[0] = '{0, 1'b0, 280, 95555};
    vecs[1] = '{1, 1'b0, 721, 85132};
    vecs[2] = '{3, 1'b0, 2163, 95555};
    vecs[3] = '{3, 1'b1, 2163, 95555};
    starts  = '{2, 443, 684, 1125};
    mine_hp = '{50620, 0, 85132, 95555};

    rst = 1'b1;
    bus.sfx_req = 1'b0; bus.sfx_id = 2'd0; bus.mute = 1'b0; bus.audio_out_allowed = 1'b1;
    step(); step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.sfx_done, 0);
    check("rst_hp", bus.cur_half_period, 0);
    check("rst_sample", bus.left_channel_audio_out, 0);
    check("rst_write_gated", bus.write_audio_out, 0);
    rst = 1'b0;
    #1;
    check("write_follows", bus.write_audio_out, 1);

    for (int i = 0; i < 4; i++) begin
      bus.mute = vecs[i].mute;
      d0 = done_pulses;
      req_and_load(vecs[i].id);
      check("vec_busy_latency", bus.busy, 1);
      step();
      check("vec_first_hp", bus.cur_half_period, vecs[i].exp_hp);
      n = 1; nz = 0; bad = 0;
      while (!bus.sfx_done && n < 4000) begin
        step();
        n++;
        if (bus.left_channel_audio_out != 0) nz = 1;
        if (!(bus.left_channel_audio_out inside {32'd0, AMPL, NAMPL})) bad = 1;
      end
      check("vec_done_cycle", n, vecs[i].exp_cycles);
      step();
      check("vec_busy_fall", bus.busy, 0);
      check("vec_done_count", done_pulses - d0, 1);
      check("vec_sound_present", nz, !vecs[i].mute);
      check("vec_sample_levels", bad, 0);
      bus.mute = 1'b0;
    end

    // Mine: note sequence including the rest note, which must stay silent.
    d0 = done_pulses;
    req_and_load(2);
    e = 0; rest_nz = 0;
    while (!bus.sfx_done && e < 3000) begin
      for (int j = 0; j < 4; j++)
        if (e == starts[j]) check("mine_hp_seq", bus.cur_half_period, mine_hp[j]);
      if (e >= 443 && e <= 642 && bus.left_channel_audio_out != 0) rest_nz = 1;
      step();
      e++;
    end
    check("mine_done_cycle", e, 2363);
    check("mine_rest_silent", rest_nz, 0);
    step();
    check("mine_done_count", done_pulses - d0, 1);

    // Preempt flag with win, then a lower id must be dropped.
    d0 = done_pulses;
    req_and_load(1);
    repeat (100) step();
    req_and_load(3);
    step();
    check("pre_hp", bus.cur_half_period, 95555);
    repeat (50) step();
    req_and_load(0);
    step();
    check("pre_ignore_hp", bus.cur_half_period, 95555);
    e = 53;
    while (!bus.sfx_done && e < 4000) begin step(); e++; end
    check("pre_done_cycle", e, 2163);
    step();
    check("pre_done_count", done_pulses - d0, 1);

    // Request landing on the completion cycle.
    d0 = done_pulses;
    req_and_load(0);
    n = 0;
    while (!bus.sfx_done && n < 1000) begin step(); n++; end
    check("co_done_cycle", n, 280);
    req_and_load(1);
    check("co_busy", bus.busy, 1);
    step();
    check("co_hp", bus.cur_half_period, 85132);
    check("co_done_count", done_pulses - d0, 1);
    n = 1;
    while (!bus.sfx_done && n < 2000) begin step(); n++; end
    check("co_second_done", n, 721);
    step();

    // Random traffic against the schedule model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_active = 0; m_id = 0; m_start = 0; m_sample = 32'd0; t = 0;
    for (int c = 0; c < 12000; c++) begin
      rst = ($urandom_range(0, 2999) == 0);
      bus.sfx_req = ($urandom_range(0, 299) == 0);
      bus.sfx_id = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.mute = ~bus.mute;
      bus.audio_out_allowed = 1'($urandom_range(0, 1));
      #1;
      ph = 3; hp = 0; k = 0; fin = 0;
      if (m_active) locate(m_id, t - m_start, ph, hp, k, fin);
      check("r_busy", bus.busy, m_active);
      check("r_hp", bus.cur_half_period, (ph == 1) ? hp : 0);
      check("r_done", bus.sfx_done, m_active && fin && !rst);
      check("r_sample", bus.left_channel_audio_out, m_sample);
      check("r_write", bus.write_audio_out, bus.audio_out_allowed && !rst);
      if (rst) begin
        m_active = 0;
        m_sample = 32'd0;
      end else begin
        m_sample = (m_active && ph == 1 && hp != 0 && !bus.mute) ?
                   ((((k / hp) % 2) != 0) ? AMPL : NAMPL) : 32'd0;
        if (bus.sfx_req && (!m_active || fin || int'(bus.sfx_id) > m_id)) begin
          m_active = 1; m_id = int'(bus.sfx_id); m_start = t + 1;
        end else if (fin) begin
          m_active = 0;
        end
      end
      t++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.sfx_req = 1'b0;

    for (int i = 0; i < 80000 && !aux_done; i++) @(posedge clk);
    check("aux_finished", aux_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
